pcalc_arb: RTL and testbench
============================

Name: pcalc_arb

Overview:
- Round-robin arbiter that shares one pcalc pipeline (pcalc_math plus its valid/stall pipe and output FIFO) between NUM_REQ shader reservation stations.
- Each request is a packed rs_to_pcalc_t payload. The winning payload is registered into a one-entry output slot that drives the pcalc unit's upstream valid/stall port.
- A credit counter sized to the pcalc output FIFO guarantees issued work never overflows it. A source tag accompanies each issue so results can be routed back.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 192, width of the packed rs_to_pcalc_t payload.
- CREDITS, 6, number of entries in the downstream pcalc output FIFO.

Ports:
- clk, input, 1, single clock.
- rst, input, 1, asynchronous reset, active-low (asserted when 0).
- req_valid, input, NUM_REQ, per-requester valid.
- req_data, input, NUM_REQ*DATA_W, per-requester payload; requester i occupies bits [i*DATA_W +: DATA_W].
- req_stall, output, NUM_REQ, per-requester stall; transfer occurs when req_valid[i] & ~req_stall[i].
- out_valid, output, 1, slot valid toward the pcalc unit.
- out_data, output, DATA_W, slot payload.
- out_src, output, $clog2(NUM_REQ), index of the requester that owns the slot payload.
- out_stall, input, 1, pcalc upstream stall.
- credit_ret, input, 1, one-cycle pulse per pcalc output FIFO read.
- credit_err, output, 1, sticky flag: credit_ret received while credits were already full.
- stat_stall_cnt, output, 16*NUM_REQ, optional statistics bus (see Optional Feature).

Behaviour:
- Reset (rst=0, asynchronous):
  - out_valid=0, out_data=0, out_src=0.
  - req_stall all 1.
  - credit counter = CREDITS, rr pointer = 0, credit_err = 0, statistics counters = 0.
- Slot state is implicit: EMPTY when out_valid=0, FULL when out_valid=1.
- Drain: when out_valid & ~out_stall, the slot drains this cycle.
- can_load = (~out_valid | ~out_stall) & (credits != 0).
- Arbitration (combinational, evaluated only when can_load):
  - Scan requesters starting at the rr pointer and wrapping modulo NUM_REQ.
  - The first i with req_valid[i] wins; grant is one-hot.
  - req_stall[i] = ~(can_load & grant[i]). All non-winners are stalled.
- Load: on a grant, at the next edge out_data <= req_data[i], out_src <= i, out_valid <= 1, rr pointer <= (i+1) mod NUM_REQ.
- No grant: the rr pointer holds. If the slot drained, out_valid <= 0. If the slot is stalled, out_data and out_src hold.
- Latency: one cycle from accepted request to out_valid. Back-to-back issue is possible every cycle while credits remain and out_stall=0.
- Credits:
  - Decrement on each grant (acceptance into the slot), not on the output handshake.
  - Increment on credit_ret.
  - Grant and credit_ret in the same cycle: count unchanged.
  - credits=0: no grant; req_stall all 1; the slot still drains normally.
  - credit_ret while credits=CREDITS and no simultaneous grant: count stays at CREDITS and credit_err <= 1 (sticky until reset).
  - Counter width is $clog2(CREDITS+1) and never wraps.
- Fairness: any requester holding req_valid high is granted within NUM_REQ grants.
- Requester obligation: requesters must not drop req_valid or change req_data while stalled. The arbiter does not check this.
- Reset mid-operation: the slot contents are discarded and credits restore to CREDITS. The pcalc unit must be reset on the same rst.

Optional Feature:
- Macro: PCALC_ARB_STATS_EN.
- Defined:
  - One 16-bit saturating counter per requester on stat_stall_cnt, slice [i*16 +: 16].
  - Counter i increments each cycle req_valid[i] & req_stall[i]; it saturates at 16'hFFFF.
  - Counters clear on reset.
- Undefined: stat_stall_cnt is tied to 0 and no counter flops are synthesized.

Test Plan:
- Single requester: req 2 valid with data 0xA5..., out_stall=0 → out_valid high the next cycle, out_src=2, credits 6→5; credit_ret pulse → credits back to 6.
- All 4 requesters valid continuously, credit_ret each cycle, out_stall=0 → out_src sequence 0,1,2,3,0,1,…; one grant per cycle.
- No credit_ret with requester 1 always valid → exactly 6 issues, then req_stall[1]=1 indefinitely. One credit_ret pulse → exactly one further issue.
- out_stall=1 for 5 cycles with the slot full → out_data and out_src stable; no new grant; after release, the next grant lands the cycle the slot drains.
- credit_ret with credits=6 and no grant → credit_err=1 and count stays 6. Then assert rst=0 asynchronously mid-cycle → credit_err=0, out_valid=0, credits=6 immediately.
- With PCALC_ARB_STATS_EN, requesters 0 and 3 valid, credits=0 for 10 cycles → stat_stall_cnt slices 0 and 3 both read 10; slices 1 and 2 read 0.

Source files
------------

// File: rtl/pcalc_arb.sv
// rtl/pcalc_arb.sv - round-robin arbiter sharing one credited pcalc pipeline slot between NUM_REQ requesters
// Optional stall statistics: PCALC_ARB_STATS_EN.
module pcalc_arb #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 192,
    parameter int CREDITS = 6
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]    req_data,
    output logic [NUM_REQ-1:0]           req_stall,
    output logic                         out_valid,
    output logic [DATA_W-1:0]            out_data,
    output logic [$clog2(NUM_REQ)-1:0]   out_src,
    input  logic                         out_stall,
    input  logic                         credit_ret,
    output logic                         credit_err,
    output logic [16*NUM_REQ-1:0]        stat_stall_cnt
);

    localparam int SW = $clog2(NUM_REQ);
    localparam int CW = $clog2(CREDITS + 1);
    localparam logic [SW:0]   NREQ = (SW + 1)'(NUM_REQ);
    localparam logic [CW-1:0] CMAX = CW'(CREDITS);

    logic [SW-1:0]      rr_ptr;
    logic [CW-1:0]      credits;
    logic               can_load;
    logic               found;
    logic               grant_any;
    logic [SW-1:0]      gidx;
    logic [NUM_REQ-1:0] grant;
    logic [SW:0]        scan_idx;
    logic [SW:0]        next_rr;
    logic [DATA_W-1:0]  grant_data;

    // Reset is folded in so requesters see a full stall while the unit is held in reset.
    assign can_load  = rst & (~out_valid | ~out_stall) & (credits != '0);
    assign grant_any = can_load & found;
    assign req_stall = ~({NUM_REQ{can_load}} & grant);

    always_comb begin
        found    = 1'b0;
        gidx     = '0;
        grant    = '0;
        scan_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = {1'b0, rr_ptr} + (SW + 1)'(k);
            if (scan_idx >= NREQ) begin
                scan_idx = scan_idx - NREQ;
            end
            if (!found && req_valid[scan_idx[SW-1:0]]) begin
                found = 1'b1;
                gidx  = scan_idx[SW-1:0];
            end
        end
        if (found) begin
            grant[gidx] = 1'b1;
        end
    end

    always_comb begin
        grant_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                grant_data = req_data[i*DATA_W +: DATA_W];
            end
        end
        next_rr = {1'b0, gidx} + (SW + 1)'(1);
        if (next_rr == NREQ) begin
            next_rr = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_src    <= '0;
            rr_ptr     <= '0;
            credits    <= CMAX;
            credit_err <= 1'b0;
        end else begin
            if (grant_any) begin
                out_valid <= 1'b1;
                out_data  <= grant_data;
                out_src   <= gidx;
                rr_ptr    <= next_rr[SW-1:0];
            end else if (out_valid && !out_stall) begin
                out_valid <= 1'b0;
            end

            // A grant and a return in the same cycle cancel out.
            case ({grant_any, credit_ret})
                2'b10: credits <= credits - CW'(1);
                2'b01: begin
                    if (credits == CMAX) begin
                        credit_err <= 1'b1;
                    end else begin
                        credits <= credits + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef PCALC_ARB_STATS_EN
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
        logic [15:0] cnt;
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                cnt <= '0;
            end else if (req_valid[g] && req_stall[g] && cnt != 16'hFFFF) begin
                cnt <= cnt + 16'd1;
            end
        end
        assign stat_stall_cnt[g*16 +: 16] = cnt;
    end
`else
    assign stat_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pcalc_arb.sv
// tb/tb_pcalc_arb.sv - vector table, directed corner sequences and randomized model check for pcalc_arb
module tb_pcalc_arb;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 192;
    localparam int CREDITS = 6;

    logic                       clk = 1'b0;
    logic                       rst;
    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ*DATA_W-1:0]  req_data;
    logic [NUM_REQ-1:0]         req_stall;
    logic                       out_valid;
    logic [DATA_W-1:0]          out_data;
    logic [1:0]                 out_src;
    logic                       out_stall;
    logic                       credit_ret;
    logic                       credit_err;
    logic [16*NUM_REQ-1:0]      stat_stall_cnt;

    pcalc_arb #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .CREDITS(CREDITS)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_stall(req_stall), .out_valid(out_valid), .out_data(out_data),
        .out_src(out_src), .out_stall(out_stall), .credit_ret(credit_ret),
        .credit_err(credit_err), .stat_stall_cnt(stat_stall_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [DATA_W-1:0] pdata [NUM_REQ];

    typedef struct {
        logic [3:0] rv;
        logic       os;
        logic       cr;
        logic [3:0] exp_stall;
        logic       exp_valid;
        logic [1:0] exp_src;
    } vec_t;
    vec_t tbl [7];

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] pat(input int i);
        logic [7:0] b;
        b = 8'hA3 + 8'(i);
        return {(DATA_W/8){b}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_data();
        for (int i = 0; i < NUM_REQ; i++) req_data[i*DATA_W +: DATA_W] = pdata[i];
    endtask

    task automatic do_reset();
        rst = 1'b0;
        req_valid = '0;
        out_stall = 1'b0;
        credit_ret = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) pdata[i] = pat(i);
        drive_data();
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic count_issues(input int r, input int n, output int cnt);
        cnt = 0;
        for (int c = 0; c < n; c++) begin
            req_valid = '0;
            req_valid[r] = 1'b1;
            #1;
            if (req_valid[r] && !req_stall[r]) cnt++;
            tick();
        end
        req_valid = '0;
    endtask

    int cnt;
    int m_cred, m_rr, m_src, win, idx;
    bit m_valid, can;
    bit pend [NUM_REQ];
    logic [DATA_W-1:0] m_data;
    logic [3:0] exp_stall;
    logic [15:0] e_stat;

    initial begin
        tbl[0] = '{4'b0100, 1'b0, 1'b0, 4'b1011, 1'b1, 2'd2};
        tbl[1] = '{4'b0000, 1'b0, 1'b1, 4'b1111, 1'b0, 2'd2};
        tbl[2] = '{4'b1111, 1'b0, 1'b0, 4'b0111, 1'b1, 2'd3};
        tbl[3] = '{4'b1111, 1'b1, 1'b0, 4'b1111, 1'b1, 2'd3};
        tbl[4] = '{4'b1111, 1'b0, 1'b1, 4'b1110, 1'b1, 2'd0};
        tbl[5] = '{4'b1111, 1'b0, 1'b0, 4'b1101, 1'b1, 2'd1};
        tbl[6] = '{4'b0000, 1'b0, 1'b0, 4'b1111, 1'b0, 2'd1};

        // Reset state, with requests already present
        do_reset();
        rst = 1'b0;
        req_valid = '1;
        #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_data", out_data, 0);
        chk("reset_out_src", out_src, 0);
        chk("reset_req_stall", req_stall, 4'b1111);
        chk("reset_credit_err", credit_err, 0);
        chk("reset_stats", stat_stall_cnt, 0);
        tick();
        req_valid = '0;
        rst = 1'b1;

        // Vector table
        for (int v = 0; v < 7; v++) begin
            req_valid = tbl[v].rv;
            out_stall = tbl[v].os;
            credit_ret = tbl[v].cr;
            #1;
            chk($sformatf("tbl%0d_req_stall", v), req_stall, tbl[v].exp_stall);
            tick();
            chk($sformatf("tbl%0d_out_valid", v), out_valid, tbl[v].exp_valid);
            if (tbl[v].exp_valid) begin
                chk($sformatf("tbl%0d_out_src", v), out_src, tbl[v].exp_src);
                chk($sformatf("tbl%0d_out_data", v), out_data, pat(tbl[v].exp_src));
            end
        end
        credit_ret = 1'b0;

        // Credit exhaustion then a single return
        do_reset();
        count_issues(1, 10, cnt);
        chk("exhaust_issues", cnt, CREDITS);
        req_valid = 4'b0010;
        #1;
        chk("exhaust_stall1", req_stall[1], 1);
        credit_ret = 1'b1;
        #1;
        chk("exhaust_stall_ret_cycle", req_stall[1], 1);
        tick();
        credit_ret = 1'b0;
        count_issues(1, 5, cnt);
        chk("one_return_one_issue", cnt, 1);

        // Output stall holds slot contents
        do_reset();
        req_valid = 4'b0001;
        tick();
        req_valid = 4'b0010;
        out_stall = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("hold_req_stall", req_stall, 4'b1111);
            tick();
            chk("hold_out_valid", out_valid, 1);
            chk("hold_out_src", out_src, 0);
            chk("hold_out_data", out_data, pat(0));
        end
        out_stall = 1'b0;
        #1;
        chk("release_req_stall", req_stall, 4'b1101);
        tick();
        chk("release_out_valid", out_valid, 1);
        chk("release_out_src", out_src, 1);
        chk("release_out_data", out_data, pat(1));
        req_valid = '0;

        // Credit overflow flag and asynchronous reset mid-cycle
        do_reset();
        credit_ret = 1'b1;
        tick();
        credit_ret = 1'b0;
        chk("credit_err_set", credit_err, 1);
        tick();
        tick();
        chk("credit_err_sticky", credit_err, 1);
        req_valid = 4'b0001;
        out_stall = 1'b1;
        tick();
        req_valid = '0;
        chk("pre_reset_valid", out_valid, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("async_credit_err", credit_err, 0);
        chk("async_out_valid", out_valid, 0);
        chk("async_out_src", out_src, 0);
        out_stall = 1'b0;
        tick();
        rst = 1'b1;
        count_issues(1, 10, cnt);
        chk("credits_restored", cnt, CREDITS);

        // Stall statistics with zero credits
        do_reset();
        count_issues(1, CREDITS, cnt);
        chk("stats_prefill", cnt, CREDITS);
        req_valid = 4'b1001;
        for (int c = 0; c < 10; c++) tick();
        req_valid = '0;
`ifdef PCALC_ARB_STATS_EN
        e_stat = 16'd10;
`else
        e_stat = 16'd0;
`endif
        chk("stat0", stat_stall_cnt[0 +: 16], e_stat);
        chk("stat1", stat_stall_cnt[16 +: 16], 0);
        chk("stat2", stat_stall_cnt[32 +: 16], 0);
        chk("stat3", stat_stall_cnt[48 +: 16], e_stat);

        // Randomized traffic against a behavioural model
        do_reset();
        m_cred = CREDITS;
        m_rr = 0;
        m_valid = 0;
        m_src = 0;
        m_data = '0;
        for (int i = 0; i < NUM_REQ; i++) pend[i] = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1) begin
                    pend[i] = 1;
                    pdata[i] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
                end
                req_valid[i] = pend[i];
            end
            drive_data();
            out_stall = ($urandom_range(0, 3) == 0);
            credit_ret = (m_cred < CREDITS) && ($urandom_range(0, 2) == 0);
            #1;
            can = (!m_valid || !out_stall) && m_cred > 0;
            win = -1;
            if (can) begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    idx = (m_rr + k) % NUM_REQ;
                    if (win < 0 && pend[idx]) win = idx;
                end
            end
            exp_stall = '1;
            if (win >= 0) exp_stall[win] = 1'b0;
            chk("rand_req_stall", req_stall, exp_stall);
            tick();
            if (win >= 0) begin
                m_valid = 1;
                m_data = pdata[win];
                m_src = win;
                m_rr = (win + 1) % NUM_REQ;
                pend[win] = 0;
                m_cred--;
            end else if (m_valid && !out_stall) begin
                m_valid = 0;
            end
            if (credit_ret) m_cred++;
            chk("rand_out_valid", out_valid, m_valid);
            if (m_valid) begin
                chk("rand_out_src", out_src, m_src);
                chk("rand_out_data", out_data, m_data);
            end
            chk("rand_credit_err", credit_err, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
